switch_debounce: RTL and testbench

Four-channel push-button conditioner sitting directly upstream of the display-mode state machine. Each raw, asynchronous switch input is synchronised into the clock domain, debounced by a per-channel stability counter, and presented as a clean level. Optional single-cycle press/release pulses let the downstream state machine act on edges without keeping its own previous-value registers.

---
 rtl/switch_debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/switch_debounce.sv | 49 ++++
 tb/tb_switch_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_pkg
//   Shared constants for the push-button conditioner and its downstream
//   display-mode state machine.
//
//   DEBOUNCE_10MS_25MHZ : default stability count (10 ms at 25 MHz)
//   DEFAULT_WIDTH       : default number of switch channels
//   countWidth()        : width of a stability counter able to hold the
//                         debounce count without wrapping
//
//   Optional feature macro used by the design: SWITCH_DEBOUNCE_EDGE_EN
// -----------------------------------------------------------------------------
package switch_debounce_pkg;

  localparam int DEBOUNCE_10MS_25MHZ = 250000;
  localparam int DEFAULT_WIDTH       = 4;

  function automatic int countWidth(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One switch channel: two-flop synchroniser, stability counter and, when
//   SWITCH_DEBOUNCE_EDGE_EN is defined, registered press/release pulses.
//
//   Parameters
//     g_DEBOUNCE_CYCLES : consecutive synchronised cycles a new level must
//                         hold before it is accepted (>= 1)
//   Ports
//     i_Clk      : system clock, rising edge
//     i_Rst_L    : asynchronous active-low reset
//     i_Switch   : raw asynchronous switch level, 1 = pressed
//     o_Switch   : debounced level
//     o_Press    : one-cycle pulse when o_Switch rises (0 if macro undefined)
//     o_Release  : one-cycle pulse when o_Switch falls (0 if macro undefined)
//
//   Configuration macro: SWITCH_DEBOUNCE_EDGE_EN
// -----------------------------------------------------------------------------
module debounce_channel
  import switch_debounce_pkg::*;
#(
  parameter int g_DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  localparam int c_CNT_W = countWidth(g_DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(g_DEBOUNCE_CYCLES - 1);

  logic               r_Sync1;
  logic               r_Sync2;
  logic               r_Level;
  logic [c_CNT_W-1:0] r_Count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1 <= 1'b0;
      r_Sync2 <= 1'b0;
    end else begin
      r_Sync1 <= i_Switch;
      r_Sync2 <= r_Sync1;
    end
  end

  // Any cycle where the synchronised input matches the accepted level
  // discards the partial count, so only an uninterrupted run is accepted.
  // The counter tops out at c_LAST and clears on acceptance, so it never wraps.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
      r_Level <= 1'b0;
    end else if (r_Sync2 == r_Level) begin
      r_Count <= '0;
    end else if (r_Count == c_LAST) begin
      r_Level <= r_Sync2;
      r_Count <= '0;
    end else begin
      r_Count <= r_Count + 1'b1;
    end
  end

  assign o_Switch = r_Level;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic w_Accept;
  logic r_Press;
  logic r_Release;

  assign w_Accept = (r_Sync2 != r_Level) && (r_Count == c_LAST);

  // Pulses are registered on the same edge that updates r_Level, so they
  // line up exactly with the debounced transition.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
    end else begin
      r_Press   <= w_Accept &  r_Sync2;
      r_Release <= w_Accept & ~r_Sync2;
    end
  end

  assign o_Press   = r_Press;
  assign o_Release = r_Release;
`else
  assign o_Press   = 1'b0;
  assign o_Release = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//   Multi-channel push-button conditioner: every raw switch input is
//   synchronised, debounced and presented as a clean level, with optional
//   single-cycle press/release pulses for the downstream state machine.
//
//   Parameters
//     g_DEBOUNCE_CYCLES : stability count in clock cycles (>= 1)
//     g_WIDTH           : number of switch channels
//   Ports
//     i_Clk       : system clock, rising edge
//     i_Rst_L     : asynchronous active-low reset
//     i_Switches  : raw asynchronous switch levels, 1 = pressed
//     o_Switches  : debounced level per channel
//     o_Press     : one-cycle pulse per channel on debounced 0->1
//     o_Release   : one-cycle pulse per channel on debounced 1->0
//
//   Configuration macro: SWITCH_DEBOUNCE_EDGE_EN
//     defined   : o_Press / o_Release generated
//     undefined : o_Press / o_Release tied to 0, ports kept
// -----------------------------------------------------------------------------
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int g_DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
  parameter int g_WIDTH           = DEFAULT_WIDTH
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [g_WIDTH-1:0] i_Switches,
  output logic [g_WIDTH-1:0] o_Switches,
  output logic [g_WIDTH-1:0] o_Press,
  output logic [g_WIDTH-1:0] o_Release
);

  for (genvar n = 0; n < g_WIDTH; n++) begin : g_Chan
    debounce_channel #(
      .g_DEBOUNCE_CYCLES(g_DEBOUNCE_CYCLES)
    ) u_Chan (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Switch  (i_Switches[n]),
      .o_Switch  (o_Switches[n]),
      .o_Press   (o_Press[n]),
      .o_Release (o_Release[n])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//   Directed bench for switch_debounce (g_DEBOUNCE_CYCLES = 8, g_WIDTH = 4).
//   A window-based reference model predicts every output on every cycle;
//   a few hand-computed literal checks pin the model at key points.
//   Press/release expectations follow SWITCH_DEBOUNCE_EDGE_EN.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int N = 8;
  localparam int W = 4;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw    = '0;
  logic [W-1:0] oSwitches;
  logic [W-1:0] oPress;
  logic [W-1:0] oRelease;

  int vecCount  = 0;
  int missCount = 0;
  bit checkEn   = 1'b0;

  switch_debounce #(
    .g_DEBOUNCE_CYCLES(N),
    .g_WIDTH(W)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switches (sw),
    .o_Switches (oSwitches),
    .o_Press    (oPress),
    .o_Release  (oRelease)
  );

  always #5 clk = ~clk;

  // Reference model: an input sampled at edge k is seen by the debouncer
  // two edges later; a channel flips once its last N seen values all
  // differ from the current debounced level.
  logic [W-1:0] inQ[$];
  logic [W-1:0] winQ[$];
  logic [W-1:0] mOut, mPress, mRel, mS2, tmp;
  bit           allDiff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inQ.delete();
      winQ.delete();
      mOut   = '0;
      mPress = '0;
      mRel   = '0;
    end else begin
      mS2 = (inQ.size() == 2) ? inQ[0] : '0;
      inQ.push_back(sw);
      if (inQ.size() > 2) inQ.delete(0);
      winQ.push_back(mS2);
      if (winQ.size() > N) winQ.delete(0);
      mPress = '0;
      mRel   = '0;
      if (winQ.size() == N) begin
        for (int ch = 0; ch < W; ch++) begin
          allDiff = 1'b1;
          for (int j = 0; j < N; j++) begin
            tmp = winQ[j];
            if (tmp[ch] == mOut[ch]) allDiff = 1'b0;
          end
          if (allDiff) begin
            mOut[ch] = ~mOut[ch];
            if (mOut[ch]) mPress[ch] = 1'b1;
            else          mRel[ch]   = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_switches", oSwitches, mOut);
      checkOutput("model_press",    oPress,    EDGE_EN ? mPress : '0);
      checkOutput("model_release",  oRelease,  EDGE_EN ? mRel   : '0);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] value, input int cycles);
    sw = value;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_switches", oSwitches, 4'b0000);
    checkOutput("reset_press",    oPress,    4'b0000);
    checkOutput("reset_release",  oRelease,  4'b0000);

    // Channel 0 held high from the first edge after reset release.
    rst_n = 1'b1;
    applyStimulus(4'b0001, 9);
    checkOutput("ch0_before_accept", oSwitches, 4'b0000);
    applyStimulus(4'b0001, 1);
    checkOutput("ch0_accept",        oSwitches, 4'b0001);
    checkOutput("ch0_press_pulse",   oPress,    EDGE_EN ? 4'b0001 : 4'b0000);
    applyStimulus(4'b0001, 1);
    checkOutput("ch0_press_end",     oPress,    4'b0000);
    checkOutput("ch0_level_held",    oSwitches, 4'b0001);

    // Channel 1 bounces: 5 high, 1 low, then steady high.
    applyStimulus(4'b0011, 5);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0011, 9);
    checkOutput("ch1_bounce_hold",   oSwitches, 4'b0001);
    applyStimulus(4'b0011, 1);
    checkOutput("ch1_accept",        oSwitches, 4'b0011);

    // Channels 2 and 3 pressed, then released together.
    applyStimulus(4'b1111, 12);
    checkOutput("all_pressed",       oSwitches, 4'b1111);
    applyStimulus(4'b0011, 9);
    checkOutput("rel_before",        oRelease,  4'b0000);
    applyStimulus(4'b0011, 1);
    checkOutput("rel_pulse",         oRelease,  EDGE_EN ? 4'b1100 : 4'b0000);
    checkOutput("rel_level",         oSwitches, 4'b0011);
    applyStimulus(4'b0011, 1);
    checkOutput("rel_end",           oRelease,  4'b0000);

    // Asynchronous reset mid-cycle with o_Switches = 0101.
    applyStimulus(4'b0101, 12);
    checkOutput("pre_reset_level",   oSwitches, 4'b0101);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_switches", oSwitches, 4'b0000);
    checkOutput("async_rst_press",    oPress,    4'b0000);
    checkOutput("async_rst_release",  oRelease,  4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0000, 3);

    // Reset pulsed while channel 0's count is at 5.
    applyStimulus(4'b0001, 7);
    checkOutput("mid_count_level",   oSwitches, 4'b0000);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0001, 9);
    checkOutput("post_rst_no_early", oSwitches, 4'b0000);
    checkOutput("post_rst_no_press", oPress,    4'b0000);
    applyStimulus(4'b0001, 1);
    checkOutput("post_rst_accept",   oSwitches, 4'b0001);
    checkOutput("post_rst_press",    oPress,    EDGE_EN ? 4'b0001 : 4'b0000);

    applyStimulus(4'b0001, 3);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
